run_detector_n: RTL and testbench
=================================

# run_detector_n

Parametrised, multi-channel successor to the single-input "w held high" FSM. Each of CHANNELS inputs has its own saturating run counter, and a channel fires once its input has been sampled high on RUN_LEN consecutive clock edges. The output form is selectable at run time: a level that stays asserted while the run continues, or a single-cycle pulse per run. A shared saturating detection counter and an any-channel flag feed the board top level, which drives LEDR and HEX displays from them.

## Interface

Parameters:
- CHANNELS, default 1: number of independent input channels (≥1).
- RUN_LEN, default 2: consecutive high samples required to detect (≥1).
- CNT_W, default 8: width of the detection counter (≥1).

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high; clears all state on the next rising edge.
- w, input, CHANNELS: per-channel input, sampled every rising edge.
- mode, input, 1: output form; 0 = level, 1 = pulse.
- clear, input, 1: synchronous clear of det_count only.
- out, output, CHANNELS: per-channel detect output.
- any_out, output, 1: OR of all out bits.
- det_count, output, CNT_W: saturating count of detections across all channels.

## Operation

- Per channel i, run_cnt[i] is ceil(log2(RUN_LEN+1)) bits wide:
  - w[i]=1: run_cnt ← min(run_cnt+1, RUN_LEN). It saturates and never wraps.
  - w[i]=0: run_cnt ← 0.
- Detection event, hit[i]: run_cnt[i] goes from RUN_LEN−1 to RUN_LEN on this edge. This happens at most once per unbroken run.
- pulse_q[i] is a register loaded with hit[i] every edge, independent of mode.
- Output selection:
  - out[i] = mode ? pulse_q[i] : (run_cnt[i] == RUN_LEN).
  - mode is purely a combinational output select. Changing mode mid-run alters no state.
- any_out = |out.
- det_count update per edge, in priority order:
  - reset: det_count ← 0.
  - clear: det_count ← 0. Hits on this edge are discarded.
  - otherwise: det_count ← min(det_count + popcount(hit), 2^CNT_W − 1).
- Simultaneous hits on k channels in one edge add k. The add must not wrap when near saturation.
- reset has the following effect on the next edge:
  - run_cnt, pulse_q and det_count all go to 0, so out=0, any_out=0, det_count=0.
  - reset overrides w and clear.
  - A run in progress is discarded. RUN_LEN fresh high samples are needed after reset deasserts.
- RUN_LEN=1: a channel hits on the first edge that samples w=1.

## Timing

- Outputs are Moore: a function of registered state plus the mode select only. There is no combinational path from w or clear to out, any_out or det_count.
- Level mode:
  - out[i] rises in the cycle after the RUN_LEN-th consecutive edge sampling w[i]=1.
  - It falls in the cycle after the first edge sampling w[i]=0.
- Pulse mode: out[i] is high for exactly one cycle, the cycle after the hit edge. It does not re-pulse until w[i] has been sampled 0 and a new run completes.
- det_count reflects a hit in the same cycle its pulse_q is visible.
- Latency from the RUN_LEN-th sample to visible output: 0 cycles after that edge.
- Reset state: every output is 0.

## Test plan

Bench configuration: CHANNELS=4, RUN_LEN=3, CNT_W=4.

- **Reset:** assert reset 1 cycle with w=4'hF → out=0, any_out=0, det_count=0 after the edge. Deassert → out[3:0] high only after 3 further edges, not earlier.
- **Level run:**
  - Stimulus: mode=0, w[0]=1 for 5 edges, then 0.
  - out[0]=0 after edges 1–2, 1 after edges 3–5, 0 after edge 6.
  - det_count=1, any_out tracks out[0].
- **Broken run:** mode=0, w[1] sequence 1,1,0,1,1,1 → out[1] stays 0 until after edge 6, then 1; det_count +1 only.
- **Pulse and simultaneous hits:**
  - Stimulus: mode=1, w[0] and w[2] high together for 6 edges.
  - out[0] and out[2] high for exactly one cycle, after edge 3.
  - det_count +2 in that cycle, no further increments.
  - Switching mode to 0 at edge 5 shows out=4'b0101 immediately.
- **Saturation and clear:**
  - Generate 17 detections → det_count=15 and holds.
  - With det_count=14 and 4 simultaneous hits → 15.
  - clear asserted on a hit edge → det_count=0 next cycle.
- **Reset mid-run:** w[3]=1 for 2 edges, reset for 1 edge with w[3]=1 still held → out[3] first asserts 3 edges after reset deasserts, det_count=1.

Source files
------------

// File: rtl/run_detector_n.sv
// Multi-channel run detector: each channel fires after RUN_LEN consecutive high samples,
// with a run-time level/pulse output select and a shared saturating detection counter.
module run_detector_n #(
    parameter int unsigned CHANNELS = 1,
    parameter int unsigned RUN_LEN  = 2,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] w,
    input  logic                mode,
    input  logic                clear,
    output logic [CHANNELS-1:0] out,
    output logic                any_out,
    output logic [CNT_W-1:0]    det_count
);
    localparam int unsigned RUN_W = $clog2(RUN_LEN + 1);
    // Extra headroom so a multi-channel add near saturation cannot wrap before the clamp.
    localparam int unsigned SUM_W = CNT_W + $clog2(CHANNELS + 1);

    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);
    localparam logic [RUN_W-1:0] RUN_PRE = RUN_W'(RUN_LEN - 1);
    localparam logic [SUM_W-1:0] CNT_MAX = {{(SUM_W - CNT_W){1'b0}}, {CNT_W{1'b1}}};

    logic [RUN_W-1:0]    r_run_cnt      [CHANNELS];
    logic [RUN_W-1:0]    w_run_cnt_next [CHANNELS];
    logic [CHANNELS-1:0] r_pulse;
    logic [CHANNELS-1:0] w_hit;
    logic [CHANNELS-1:0] w_level;
    logic [CNT_W-1:0]    r_det_count;
    logic [CNT_W-1:0]    w_det_count_next;
    logic [SUM_W-1:0]    w_hit_sum;
    logic [SUM_W-1:0]    w_cnt_sum;

    always_comb begin
        for (int i = 0; i < int'(CHANNELS); i++) begin
            w_hit[i]   = w[i] && (r_run_cnt[i] == RUN_PRE);
            w_level[i] = (r_run_cnt[i] == RUN_MAX);
            if (!w[i]) begin
                w_run_cnt_next[i] = '0;
            end else if (r_run_cnt[i] == RUN_MAX) begin
                w_run_cnt_next[i] = RUN_MAX;
            end else begin
                w_run_cnt_next[i] = r_run_cnt[i] + RUN_W'(1);
            end
        end
    end

    always_comb begin
        w_hit_sum = '0;
        for (int i = 0; i < int'(CHANNELS); i++) begin
            w_hit_sum = w_hit_sum + SUM_W'(w_hit[i]);
        end
        w_cnt_sum = SUM_W'(r_det_count) + w_hit_sum;
        if (clear) begin
            w_det_count_next = '0;
        end else if (w_cnt_sum > CNT_MAX) begin
            w_det_count_next = CNT_MAX[CNT_W-1:0];
        end else begin
            w_det_count_next = w_cnt_sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_run_cnt[i] <= '0;
            end
            r_pulse     <= '0;
            r_det_count <= '0;
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_run_cnt[i] <= w_run_cnt_next[i];
            end
            r_pulse     <= w_hit;
            r_det_count <= w_det_count_next;
        end
    end

    // mode only selects the view; it never touches state.
    assign out       = mode ? r_pulse : w_level;
    assign any_out   = |out;
    assign det_count = r_det_count;

endmodule

// File: tb/tb_run_detector_n.sv
// Bench for run_detector_n (CHANNELS=4, RUN_LEN=3, CNT_W=4): directed plan steps then random
// stimulus, all checked against a run-length reference model.
module tb_run_detector_n;
    localparam int CH   = 4;
    localparam int RL   = 3;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          mode = 1'b0;
    logic          clear = 1'b0;
    logic [CH-1:0] w = '0;
    logic [CH-1:0] out;
    logic          any_out;
    logic [CW-1:0] det_count;

    always #5 clk = ~clk;

    run_detector_n #(
        .CHANNELS(CH),
        .RUN_LEN (RL),
        .CNT_W   (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .w        (w),
        .mode     (mode),
        .clear    (clear),
        .out      (out),
        .any_out  (any_out),
        .det_count(det_count)
    );

    int tests = 0;
    int fails = 0;

    // Model: length of the current unbroken high run, whether the last edge completed a run,
    // and the total detection count.
    int m_run   [CH];
    bit m_pulse [CH];
    int m_cnt;

    function automatic logic [CH-1:0] exp_out();
        logic [CH-1:0] r;
        for (int i = 0; i < CH; i++) begin
            r[i] = mode ? m_pulse[i] : (m_run[i] >= RL);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [CH-1:0] e;
        e = exp_out();
        check({tag, ".out"}, 32'(out), 32'(e));
        check({tag, ".any_out"}, 32'(any_out), 32'(|e));
        check({tag, ".det_count"}, 32'(det_count), 32'(m_cnt));
    endtask

    task automatic step(input logic [CH-1:0] wv, input logic cl, input logic rs,
                        input string tag);
        int hits;
        w     = wv;
        clear = cl;
        reset = rs;
        @(posedge clk);
        if (rs) begin
            for (int i = 0; i < CH; i++) begin
                m_run[i]   = 0;
                m_pulse[i] = 1'b0;
            end
            m_cnt = 0;
        end else begin
            hits = 0;
            for (int i = 0; i < CH; i++) begin
                if (wv[i]) begin
                    m_run[i]   = m_run[i] + 1;
                    m_pulse[i] = (m_run[i] == RL);
                end else begin
                    m_run[i]   = 0;
                    m_pulse[i] = 1'b0;
                end
                hits += int'(m_pulse[i]);
            end
            if (cl) m_cnt = 0;
            else m_cnt = (m_cnt + hits > MAXC) ? MAXC : m_cnt + hits;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [CH-1:0] rw;

        // Reset with all inputs high, then a fresh 3-edge run.
        step(4'hF, 1'b0, 1'b1, "reset");
        check("reset.out_zero", 32'(out), 32'h0);
        check("reset.det_zero", 32'(det_count), 32'h0);
        step(4'hF, 1'b0, 1'b0, "post_reset1");
        step(4'hF, 1'b0, 1'b0, "post_reset2");
        check("post_reset2.not_yet", 32'(out), 32'h0);
        step(4'hF, 1'b0, 1'b0, "post_reset3");
        check("post_reset3.all_high", 32'(out), 32'hF);
        step(4'h0, 1'b1, 1'b0, "flush");

        // Level run on channel 0.
        mode = 1'b0;
        for (int k = 0; k < 5; k++) step(4'h1, 1'b0, 1'b0, "level_run");
        step(4'h0, 1'b0, 1'b0, "level_fall");
        check("level.det", 32'(det_count), 32'd1);

        // Broken run on channel 1: 1,1,0,1,1,1.
        step(4'h2, 1'b0, 1'b0, "broken");
        step(4'h2, 1'b0, 1'b0, "broken");
        step(4'h0, 1'b0, 1'b0, "broken");
        step(4'h2, 1'b0, 1'b0, "broken");
        step(4'h2, 1'b0, 1'b0, "broken");
        check("broken.still_low", 32'(out[1]), 32'd0);
        step(4'h2, 1'b0, 1'b0, "broken");
        check("broken.high", 32'(out[1]), 32'd1);
        check("broken.det", 32'(det_count), 32'd2);
        step(4'h0, 1'b0, 1'b0, "broken_end");

        // Pulse mode with simultaneous hits on channels 0 and 2.
        mode = 1'b1;
        for (int k = 0; k < 4; k++) step(4'h5, 1'b0, 1'b0, "pulse");
        mode = 1'b0;
        #1;
        check_all("mode_switch");
        check("mode_switch.out", 32'(out), 32'h5);
        step(4'h5, 1'b0, 1'b0, "pulse_tail");
        step(4'h5, 1'b0, 1'b0, "pulse_tail");
        check("pulse.det", 32'(det_count), 32'd4);
        step(4'h0, 1'b1, 1'b0, "sat_clear");

        // 17 single detections saturate at 15.
        for (int n = 0; n < 17; n++) begin
            for (int k = 0; k < 3; k++) step(4'h1, 1'b0, 1'b0, "sat");
            step(4'h0, 1'b0, 1'b0, "sat_gap");
        end
        check("sat.hold15", 32'(det_count), 32'd15);

        // 14 then four simultaneous hits.
        step(4'h0, 1'b1, 1'b0, "sat_clear2");
        for (int n = 0; n < 14; n++) begin
            for (int k = 0; k < 3; k++) step(4'h8, 1'b0, 1'b0, "to14");
            step(4'h0, 1'b0, 1'b0, "to14_gap");
        end
        check("to14.det", 32'(det_count), 32'd14);
        for (int k = 0; k < 3; k++) step(4'hF, 1'b0, 1'b0, "quad");
        check("quad.sat", 32'(det_count), 32'd15);
        step(4'h0, 1'b0, 1'b0, "quad_gap");

        // Clear on a hit edge discards the hits.
        step(4'hF, 1'b0, 1'b0, "clr_hit");
        step(4'hF, 1'b0, 1'b0, "clr_hit");
        step(4'hF, 1'b1, 1'b0, "clr_hit");
        check("clr_hit.det", 32'(det_count), 32'd0);
        step(4'h0, 1'b0, 1'b0, "clr_gap");

        // Reset mid-run on channel 3.
        step(4'h8, 1'b0, 1'b0, "midrun");
        step(4'h8, 1'b0, 1'b0, "midrun");
        step(4'h8, 1'b0, 1'b1, "midrun_reset");
        step(4'h8, 1'b0, 1'b0, "midrun_after");
        step(4'h8, 1'b0, 1'b0, "midrun_after");
        check("midrun.not_yet", 32'(out[3]), 32'd0);
        step(4'h8, 1'b0, 1'b0, "midrun_after");
        check("midrun.out3", 32'(out[3]), 32'd1);
        check("midrun.det", 32'(det_count), 32'd1);

        // Randomized traffic, biased towards long runs.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < CH; i++) rw[i] = ($urandom_range(3) != 0);
            mode = 1'($urandom_range(1));
            step(rw, ($urandom_range(15) == 0), ($urandom_range(40) == 0), "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
